// File: rtl/mem_apb_ws.sv
// APB3/APB4 scratch memory with programmable wait states, byte strobes and PSLVERR.
// Define MEM_APB_PROT_EN to add the PPROT port and the privileged low region check.
module mem_apb_ws #(
  parameter int SIZE_IN_BYTES = 4096,
  parameter int DW            = 32,
  parameter int WAIT_STATES   = 0,
  parameter int PROT_BYTES    = 256
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic [31:0]     PADDR,
  input  logic            PWRITE,
  input  logic [DW-1:0]   PWDATA,
  input  logic [DW/8-1:0] PSTRB,
`ifdef MEM_APB_PROT_EN
  input  logic [2:0]      PPROT,
`endif
  output logic [DW-1:0]   PRDATA,
  output logic            PREADY,
  output logic            PSLVERR
);

  localparam int NB    = DW / 8;
  localparam int LB    = $clog2(NB);
  localparam int AW    = $clog2(SIZE_IN_BYTES);
  localparam int IW    = AW - LB;
  localparam int DEPTH = SIZE_IN_BYTES / NB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nx;
  logic            r_bad;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_setup;
  logic            w_xfer_done;
  logic            w_wr_en;
  logic            w_bad;
  logic            w_prot_bad;
  logic [IW-1:0]   w_idx;

  assign w_idx = PADDR[AW-1:LB];

`ifdef MEM_APB_PROT_EN
  logic w_unused_pprot;
  assign w_unused_pprot = ^PPROT[2:1];
  assign w_prot_bad     = ~PPROT[0] & (PADDR < 32'(PROT_BYTES));
`else
  assign w_prot_bad     = 1'b0;
`endif

  assign w_bad = (PADDR >= 32'(SIZE_IN_BYTES)) |
                 ((PADDR & 32'(NB - 1)) != 32'd0) |
                 w_prot_bad;

  assign w_setup     = (r_state == S_IDLE) & PSEL & ~PENABLE;
  assign w_xfer_done = (r_state == S_READY) & PSEL & PENABLE;
  assign w_wr_en     = w_xfer_done & PWRITE & ~r_bad;

  // Response is only driven in the completion cycle; zero everywhere else.
  assign PREADY  = w_xfer_done;
  assign PSLVERR = w_xfer_done & r_bad;
  assign PRDATA  = (w_xfer_done & ~PWRITE & ~r_bad) ? r_rdata : '0;

  // State, wait counter and the address decode captured at setup.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_bad   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_setup) begin
        r_bad <= w_bad;
        r_idx <= w_idx;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> READY -> IDLE.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_cnt_nx   = 4'(WAIT_STATES);
          w_state_nx = (WAIT_STATES > 0) ? S_WAIT : S_READY;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nx = S_READY;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx   = r_cnt - 4'd1;
        end
      end
      S_READY: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 4'd0;
      end
    endcase
  end

  // Unreset storage: lane-masked write at completion, registered read at setup.
  always_ff @(posedge PCLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) begin
          r_mem[r_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
        end
      end
    end
    if (w_setup) begin
      r_rdata <= r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_mem_apb_ws.sv
// Directed bench for mem_apb_ws: one zero-wait and one three-wait instance on a shared bus.
module tb_mem_apb_ws;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int total = 0;
  int bad   = 0;
  int nz_in_wait;
  int spurious;

  logic [31:0] rd;
  logic        err;
  int          waits;

  always #5 PCLK = ~PCLK;

  mem_apb_ws #(.SIZE_IN_BYTES(4096), .DW(32), .WAIT_STATES(0), .PROT_BYTES(256)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef MEM_APB_PROT_EN
    .PPROT(pprot),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  mem_apb_ws #(.SIZE_IN_BYTES(4096), .DW(32), .WAIT_STATES(3), .PROT_BYTES(256)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef MEM_APB_PROT_EN
    .PPROT(pprot),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the completion edge.
  task automatic xfer(input bit sel3, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rdo, output logic erro, output int nwait);
    bit done;
    done  = 1'b0;
    nwait = 0;
    rdo   = 32'd0;
    erro  = 1'b0;
    psel0 = ~sel3; psel3 = sel3; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    @(posedge PCLK); #1 penable = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge PCLK);
      if ((sel3 ? pready3 : pready0) === 1'b1) begin
        done = 1'b1;
        rdo  = sel3 ? prdata3 : prdata0;
        erro = sel3 ? pslverr3 : pslverr0;
      end else begin
        nwait++;
        if ((sel3 ? prdata3 : prdata0) !== 32'd0) nz_in_wait++;
      end
      @(posedge PCLK); #1;
    end
    chk("xfer_completes", {31'd0, done}, 32'd1);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0; pprot = 3'b001;
    nz_in_wait = 0; spurious = 0;
    #22;
    chk("rst_pready0",  {31'd0, pready0},  32'd0);
    chk("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata0",  prdata0,           32'd0);
    chk("rst_pready3",  {31'd0, pready3},  32'd0);
    chk("rst_prdata3",  prdata3,           32'd0);
    @(negedge PCLK) PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait write/read, back-to-back.
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, waits);
    chk("zw_wr_err", {31'd0, err}, 32'd0);
    chk("zw_wr_waits", waits, 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits);
    chk("zw_rd_data", rd, 32'hDEADBEEF);
    chk("zw_rd_err", {31'd0, err}, 32'd0);
    chk("zw_rd_waits", waits, 32'd0);

    // Byte strobes.
    xfer(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, waits);
    xfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, err, waits);
    xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, waits);
    chk("strb_merge", rd, 32'h11BB33DD);

    // PSTRB=0 is an OKAY no-op.
    xfer(1'b0, 1'b1, 32'h10, 32'h00000000, 4'h0, rd, err, waits);
    chk("strb0_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits);
    chk("strb0_data", rd, 32'hDEADBEEF);

    // Last word and error responses.
    xfer(1'b0, 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, rd, err, waits);
    xfer(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, err, waits);
    chk("last_word", rd, 32'hA5A5A5A5);
    xfer(1'b0, 1'b1, 32'h0, 32'h55667788, 4'hF, rd, err, waits);
    xfer(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, err, waits);
    chk("oor_rd_err", {31'd0, err}, 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    xfer(1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, rd, err, waits);
    chk("mis_wr_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, waits);
    chk("mis_wr_nochg", rd, 32'h55667788);
    chk("ok_after_err", {31'd0, err}, 32'd0);

    // Three wait states.
    xfer(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, err, waits);
    chk("ws3_wr_waits", waits, 32'd3);
    nz_in_wait = 0;
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, waits);
    chk("ws3_rd_waits", waits, 32'd3);
    chk("ws3_rd_data", rd, 32'hCAFEF00D);
    chk("ws3_prdata_idle", nz_in_wait, 32'd0);
    xfer(1'b1, 1'b0, 32'h1001, 32'h0, 4'h0, rd, err, waits);
    chk("ws3_err_waits", waits, 32'd3);
    chk("ws3_err", {31'd0, err}, 32'd1);
    chk("ws3_err_data", rd, 32'd0);

    // PSEL dropped during WAIT: no write, no response.
    xfer(1'b1, 1'b1, 32'h24, 32'h0BADF00D, 4'hF, rd, err, waits);
    psel3 = 1'b1; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'hFFFF0000; pstrb = 4'hF; penable = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1 psel3 = 1'b0; penable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK);
      if (pready3 !== 1'b0) spurious++;
    end
    chk("drop_no_resp", spurious, 32'd0);
    @(posedge PCLK); #1;
    xfer(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, rd, err, waits);
    chk("drop_no_write", rd, 32'h0BADF00D);

    // Reset in the completion cycle of a zero-wait write.
    psel0 = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h00000000; pstrb = 4'hF; penable = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    #1 chk("pre_rst_ready", {31'd0, pready0}, 32'd1);
    PRESETn = 1'b0;
    #1 chk("async_rst_ready", {31'd0, pready0}, 32'd0);
    chk("async_rst_slverr", {31'd0, pslverr0}, 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge PCLK) PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits);
    chk("rst_discard_wr", rd, 32'hDEADBEEF);

    // Reset in the second wait cycle.
    psel3 = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h12345678; pstrb = 4'hF; penable = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1 PRESETn = 1'b0;
    #2 chk("midwait_ready", {31'd0, pready3}, 32'd0);
    chk("midwait_slverr", {31'd0, pslverr3}, 32'd0);
    chk("midwait_prdata", prdata3, 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge PCLK) PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, waits);
    chk("midwait_unchanged", rd, 32'hCAFEF00D);
    chk("midwait_next_waits", waits, 32'd3);

`ifdef MEM_APB_PROT_EN
    // Unprivileged access to the low region is refused.
    xfer(1'b0, 1'b1, 32'h40, 32'h01020304, 4'hF, rd, err, waits);
    pprot = 3'b000;
    xfer(1'b0, 1'b1, 32'h40, 32'h99999999, 4'hF, rd, err, waits);
    chk("prot_wr_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, waits);
    chk("prot_rd_err", {31'd0, err}, 32'd1);
    chk("prot_rd_data", rd, 32'd0);
    pprot = 3'b001;
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, waits);
    chk("prot_no_write", rd, 32'h01020304);
    xfer(1'b0, 1'b1, 32'h40, 32'h99999999, 4'hF, rd, err, waits);
    chk("priv_wr_ok", {31'd0, err}, 32'd0);
    xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, waits);
    chk("priv_readback", rd, 32'h99999999);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
